pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the single-cycle and pipelined datapath.
//  It holds the fetch address, advances it by INC each cycle, and takes redirects
//  from branch, jump and return.
//  It has a hold (stall) input and a circular return-address stack (RAS) for call/return.
//  It feeds the instruction memory address port and the IF/ID PC+INC path.
// PARAMETERS
//  WIDTH         32            PC / address width in bits
//  INC           4             sequential increment (bytes per instruction)
//  RESET_VECTOR  32'h00000000  PC value loaded on reset
//  RAS_DEPTH     4             return-address stack entries (power of 2, >=2)
//  ALIGN_BITS    2             low target bits forced to 0 on every redirect
// PORTS
//  Clk           in   1      clock, all state updates on rising edge
//  Reset         in   1      synchronous, active-high
//  Stall         in   1      hold PC and RAS for this cycle (redirects still win)
//  BranchTaken   in   1      take BranchTarget
//  BranchTarget  in   WIDTH  branch destination
//  Jump          in   1      take JumpTarget
//  JumpTarget    in   WIDTH  jump destination
//  Call          in   1      qualifies Jump: also push PCResult+INC onto RAS
//  Return        in   1      pop RAS top and redirect to it
//  PCResult      out  WIDTH  current fetch address (registered)
//  PCPlusInc     out  WIDTH  PCResult+INC, combinational, mod 2^WIDTH
//  PCValid       out  1      0 during reset and the first cycle after; 1 afterwards
//  RasEmpty      out  1      RAS count == 0 (registered state)
//  RasFull       out  1      RAS count == RAS_DEPTH
//  RasUnderflow  out  1      1-cycle pulse: Return was taken with RAS empty
// BEHAVIOUR
//  Reset (sync, wins over everything):
//  - PCResult=RESET_VECTOR, PCValid=0, RAS count=0, top ptr=0, RasUnderflow=0.
//  - The first non-reset edge sets PCValid=1. PCResult does not advance on that edge.
//  Next-PC priority per edge, highest first:
//  - BranchTaken -> BranchTarget.
//  - Return -> RAS top. If the RAS is empty: PCPlusInc, and RasUnderflow pulses.
//  - Jump -> JumpTarget.
//  - Stall -> hold.
//  - else -> PCPlusInc.
//  - Redirects override Stall. Redirect latency is 1 cycle: target appears on PCResult the next cycle.
//  - Every redirect target has bits [ALIGN_BITS-1:0] cleared before loading.
//  - Sequential increment wraps modulo 2^WIDTH; there is no overflow flag.
//  RAS rules:
//  - Push: only when Jump & Call are selected (no BranchTaken, no Return).
//  - Push writes PCPlusInc at ptr+1, increments ptr, and increments count, saturating at RAS_DEPTH.
//  - Push when full overwrites the oldest entry (circular); RasFull stays 1.
//  - Pop: when Return is selected and count>0. Pop decrements ptr and count.
//  - BranchTaken in the same cycle as Call/Return: branch wins; no push or pop occurs.
//  - Jump & Return together: Return wins, and no push occurs even if Call=1.
//  - Call without Jump is ignored.
//  - Stall alone leaves the RAS unchanged.
//  - Pointer arithmetic is modulo RAS_DEPTH.
//  Reset mid-operation:
//  - Pending redirects are discarded and all RAS contents are invalidated (count=0).
//  - Stale entries are never returned.
// TESTING
//  1 Reset 2 cycles, then 3 free cycles -> PCResult 0,0(PCValid 0->1),4,8; RasEmpty=1.
//  2 Stall=1 at PC=8, 2 cycles -> PC stays 8. Stall+BranchTaken target 0x103 -> PC=0x100.
//  3 PC=0x20, Jump+Call target 0x400 -> PC=0x400, RAS top=0x24.
//    Later Return -> PC=0x24, RasEmpty=1.
//  4 RAS_DEPTH=4, 5 calls pushing A..E -> RasFull=1.
//    4 Returns give E,D,C,B. The 5th Return -> PC=PCPlusInc, RasUnderflow=1 for 1 cycle.
//  5 WIDTH=32, PC=0xFFFFFFFC, free-run -> PC=0x00000000.
//    BranchTaken+Return same edge -> branch target taken, RAS count unchanged.
//  6 Reset asserted with 2 RAS entries and Jump pending -> PC=RESET_VECTOR, RasEmpty=1.
//    A following Return gives an underflow pulse.

Source files
------------

// File: rtl/pc_unit_if.sv
// pc_unit_if: control inputs and fetch/RAS status outputs of the program-counter unit
interface pc_unit_if #(parameter int WIDTH = 32);
  logic             Stall;
  logic             BranchTaken;
  logic [WIDTH-1:0] BranchTarget;
  logic             Jump;
  logic [WIDTH-1:0] JumpTarget;
  logic             Call;
  logic             Return;
  logic [WIDTH-1:0] PCResult;
  logic [WIDTH-1:0] PCPlusInc;
  logic             PCValid;
  logic             RasEmpty;
  logic             RasFull;
  logic             RasUnderflow;
  modport master (
    output Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Call, Return,
    input  PCResult, PCPlusInc, PCValid, RasEmpty, RasFull, RasUnderflow
  );
  modport slave (
    input  Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Call, Return,
    output PCResult, PCPlusInc, PCValid, RasEmpty, RasFull, RasUnderflow
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch PC with branch/return/jump redirects, stall and a circular return-address stack
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter int               INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4,
  parameter int               ALIGN_BITS   = 2
) (
  input logic       Clk,
  input logic       Reset,
  pc_unit_if.slave  bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN_BITS;
  logic [WIDTH-1:0] r_pc;
  logic             r_valid;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [PW:0]      r_cnt;
  logic             r_unf;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_next;
  logic [PW-1:0]    w_ptr_inc;
  logic             w_empty;
  logic             w_full;
  logic             w_ret;
  logic             w_push;
  logic             w_pop;
  always_comb begin
    w_pc_inc  = r_pc + WIDTH'(INC);
    w_ptr_inc = r_ptr + 1'b1;
    w_empty   = r_cnt == '0;
    w_full    = r_cnt == (PW+1)'(RAS_DEPTH);
    w_ret     = bus.Return & ~bus.BranchTaken;
    w_push    = bus.Jump & bus.Call & ~bus.BranchTaken & ~bus.Return;
    w_pop     = w_ret & ~w_empty;
    w_next    = bus.BranchTaken ? (bus.BranchTarget & ALIGN_MASK) :
                w_ret           ? (w_empty ? w_pc_inc : (r_ras[r_ptr] & ALIGN_MASK)) :
                bus.Jump        ? (bus.JumpTarget & ALIGN_MASK) :
                bus.Stall       ? r_pc : w_pc_inc;
  end
  // The first edge after reset only raises PCValid; PC and RAS stay put.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc    <= RESET_VECTOR;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_unf   <= 1'b0;
    end else begin
      r_valid <= 1'b1;
      r_unf   <= r_valid & w_ret & w_empty;
      if (r_valid) begin
        r_pc <= w_next;
        if (w_push) begin
          r_ptr <= w_ptr_inc;
          r_cnt <= w_full ? r_cnt : r_cnt + 1'b1;
        end else if (w_pop) begin
          r_ptr <= r_ptr - 1'b1;
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset && r_valid && w_push) r_ras[w_ptr_inc] <= w_pc_inc;
  end
  assign bus.PCResult     = r_pc;
  assign bus.PCPlusInc    = w_pc_inc;
  assign bus.PCValid      = r_valid;
  assign bus.RasEmpty     = w_empty;
  assign bus.RasFull      = w_full;
  assign bus.RasUnderflow = r_unf;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: randomized and directed stimulus against a queue-based reference model of pc_unit
module tb_pc_unit;
  logic Clk = 1'b0;
  logic Reset;
  int n_checks = 0;
  int n_errors = 0;
  pc_unit_if #(.WIDTH(32)) bus();
  pc_unit dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_unf;
  logic [31:0] m_stack [$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step(input logic rst, input logic st, input logic br, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt, input logic cl, input logic rt);
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_unf = 1'b0; m_stack.delete();
    end else if (!m_valid) begin
      m_valid = 1'b1; m_unf = 1'b0;
    end else begin
      m_unf = 1'b0;
      if (br) m_pc = bt & ~32'h3;
      else if (rt) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back() & ~32'h3;
        else begin m_pc = m_pc + 32'd4; m_unf = 1'b1; end
      end else if (j) begin
        if (cl) begin
          m_stack.push_back(m_pc + 32'd4);
          if (m_stack.size() > 4) void'(m_stack.pop_front());
        end
        m_pc = jt & ~32'h3;
      end else if (!st) m_pc = m_pc + 32'd4;
    end
  endtask
  task automatic cycle(input logic rst, input logic st, input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic cl, input logic rt);
    @(negedge Clk);
    Reset = rst; bus.Stall = st; bus.BranchTaken = br; bus.BranchTarget = bt;
    bus.Jump = j; bus.JumpTarget = jt; bus.Call = cl; bus.Return = rt;
    @(posedge Clk);
    model_step(rst, st, br, bt, j, jt, cl, rt);
    #1;
    check("PCResult", bus.PCResult, m_pc);
    check("PCPlusInc", bus.PCPlusInc, m_pc + 32'd4);
    check("PCValid", 32'(bus.PCValid), 32'(m_valid));
    check("RasEmpty", 32'(bus.RasEmpty), 32'(m_stack.size() == 0));
    check("RasFull", 32'(bus.RasFull), 32'(m_stack.size() == 4));
    check("RasUnderflow", 32'(bus.RasUnderflow), 32'(m_unf));
  endtask
  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic call_to(input logic [31:0] t);
    cycle(0, 0, 0, 0, 1, t, 1, 0);
  endtask
  task automatic ret();
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  initial begin
    Reset = 1'b1;
    bus.Stall = 0; bus.BranchTaken = 0; bus.BranchTarget = 0; bus.Jump = 0;
    bus.JumpTarget = 0; bus.Call = 0; bus.Return = 0;
    m_pc = 0; m_valid = 0; m_unf = 0;
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) idle();
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 32'h103, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h20, 0, 0, 0, 0);
    call_to(32'h400);
    repeat (2) idle();
    ret();
    for (int i = 0; i < 5; i++) call_to(32'h1000 * (i + 1) + 32'h10);
    repeat (5) ret();
    idle();
    cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    idle();
    call_to(32'h800);
    cycle(0, 0, 1, 32'h600, 0, 0, 0, 1);
    cycle(0, 0, 1, 32'h700, 1, 32'h900, 1, 0);
    cycle(0, 0, 0, 0, 1, 32'hA00, 1, 1);
    cycle(0, 1, 0, 0, 1, 32'hB00, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    call_to(32'hC00);
    cycle(0, 0, 0, 0, 1, 32'hD00, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    ret();
    idle();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom(),
            $urandom_range(0, 3) == 0, $urandom(),
            $urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
